// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry FIFO that buffers ALU results with {V,C,N,Z} flags.
// Optional overflow flag generation is enabled by defining ALU_RES_OVF_EN.
module alu_result_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      F,
  input  logic             Cout,
  input  logic [3:0]       sel,
  input  logic             A_msb,
  input  logic             B_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_F,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state;
  logic [DATA_W-1:0]   skid_F;
  logic [FLAG_W-1:0]   skid_flags;
  logic                push;
  logic                pop;
  logic                flag_v;
  logic                flag_c;
  logic                flag_n;
  logic                flag_z;
  logic [FLAG_W-1:0]   new_flags;

  // Flags are derived from the incoming result and stored with the entry.
  always_comb begin
    flag_v = 1'b0;
    flag_z = (F == DATA_W'(0));
    flag_n = F[DATA_W-1];
    flag_c = (sel[3:2] == 2'b00) ? Cout : 1'b0;
`ifdef ALU_RES_OVF_EN
    case (sel)
      4'h1:    flag_v = (A_msb == B_msb) && (F[DATA_W-1] != A_msb);
      4'h2:    flag_v = (A_msb != B_msb) && (F[DATA_W-1] != A_msb);
      default: flag_v = 1'b0;
    endcase
`endif
    new_flags = {flag_v, flag_c, flag_n, flag_z};
  end

`ifndef ALU_RES_OVF_EN
  logic unused_ovf;
  assign unused_ovf = &{1'b0, A_msb, B_msb, sel[1:0]};
`endif

  always_comb begin
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
  end

  // out_F/out_flags form the head entry; skid holds the second entry in FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_F      <= '0;
      out_flags  <= '0;
      skid_F     <= '0;
      skid_flags <= '0;
      out_count  <= '0;
    end else begin
      if (push) begin
        out_count <= out_count + CNT_W'(1);
      end
      case (state)
        EMPTY: begin
          if (push) begin
            out_F     <= F;
            out_flags <= new_flags;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_F     <= F;
            out_flags <= new_flags;
          end else if (push) begin
            skid_F     <= F;
            skid_flags <= new_flags;
            in_ready   <= 1'b0;
            state      <= FULL;
          end else if (pop) begin
            out_F     <= '0;
            out_flags <= '0;
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            out_F     <= skid_F;
            out_flags <= skid_flags;
            in_ready  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          out_F     <= '0;
          out_flags <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: vector table, corner sequences and a queue scoreboard.
module tb_alu_result_stage;

  localparam int unsigned TB_CNT_W = 4;
`ifdef ALU_RES_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         F;
  logic                Cout;
  logic [3:0]          sel;
  logic                A_msb;
  logic                B_msb;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_F;
  logic [3:0]          out_flags;
  logic [TB_CNT_W-1:0] out_count;

  logic [3:0] exp_flags_drv;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_push = 0;

  typedef struct {
    logic [31:0] f;
    logic        cout;
    logic [3:0]  sel;
    logic        a;
    logic        b;
    logic [3:0]  flags;
  } vec_t;

  typedef struct packed {
    logic [31:0] f;
    logic [3:0]  flags;
  } sb_t;

  sb_t  q[$];
  sb_t  prev_out;
  logic prev_stall = 1'b0;
  vec_t vecs[9];

  alu_result_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .F(F), .Cout(Cout), .sel(sel), .A_msb(A_msb), .B_msb(B_msb),
    .out_valid(out_valid), .out_ready(out_ready), .out_F(out_F),
    .out_flags(out_flags), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent flag reference for the random phase.
  function automatic logic [3:0] flags_model(input logic [31:0] f, input logic co,
                                             input logic [3:0] s, input logic a, input logic b);
    logic v;
    v = 1'b0;
    if (OVF && s == 4'h1 && a == b && f[31] != a) v = 1'b1;
    if (OVF && s == 4'h2 && a != b && f[31] != a) v = 1'b1;
    return {v, (s < 4'h4) ? co : 1'b0, f[31], f == 32'h0};
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [31:0] f, input logic co,
                     input logic [3:0] s, input logic a, input logic b,
                     input logic [3:0] ef, input logic ordy);
    rst = r; in_valid = v; F = f; Cout = co; sel = s; A_msb = a; B_msb = b;
    exp_flags_drv = ef; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, ordy);
  endtask

  task automatic push_simple(input logic [31:0] f, input logic ordy);
    cyc(1'b0, 1'b1, f, 1'b0, 4'h0, 1'b0, 1'b0, {2'b00, f[31], f == 32'h0}, ordy);
  endtask

  // Scoreboard: record accepted pushes, compare on pops, check stall stability.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      q.delete();
      n_push = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 32'(out_valid), 32'h1);
        check("stall_hold_F", out_F, prev_out.f);
        check("stall_hold_flags", 32'(out_flags), 32'(prev_out.flags));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: got out_F=%0h expected no output", out_F);
        end else begin
          e = q.pop_front();
          check("sb_F", out_F, e.f);
          check("sb_flags", 32'(out_flags), 32'(e.flags));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({F, exp_flags_drv});
        n_push++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_F, out_flags};
    end
  end

  initial begin
    vecs[0] = '{32'h00000000, 1'b0, 4'h0, 1'b0, 1'b0, 4'b0001};
    vecs[1] = '{32'h7FFFFFFF, 1'b0, 4'h1, 1'b1, 1'b0, 4'b0000};
    vecs[2] = '{32'h00000000, 1'b1, 4'h1, 1'b1, 1'b1, {OVF, 3'b101}};
    vecs[3] = '{32'h2468ACF0, 1'b1, 4'h8, 1'b0, 1'b0, 4'b0000};
    vecs[4] = '{32'h80000000, 1'b1, 4'h2, 1'b0, 1'b1, {OVF, 3'b110}};
    vecs[5] = '{32'hFFFFFFFF, 1'b1, 4'h4, 1'b1, 1'b1, 4'b0010};
    vecs[6] = '{32'h00000001, 1'b1, 4'h3, 1'b0, 1'b0, 4'b0100};
    vecs[7] = '{32'h80000000, 1'b0, 4'h1, 1'b0, 1'b0, {OVF, 3'b010}};
    vecs[8] = '{32'h00000000, 1'b1, 4'hC, 1'b1, 1'b0, 4'b0001};

    cyc(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_count", 32'(out_count), 32'h0);
    check("rst_out_F", out_F, 32'h0);
    check("rst_flags", 32'(out_flags), 32'h0);

    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, vecs[i].f, vecs[i].cout, vecs[i].sel, vecs[i].a, vecs[i].b,
          vecs[i].flags, 1'b0);
      check("vec_valid", 32'(out_valid), 32'h1);
      check("vec_F", out_F, vecs[i].f);
      check("vec_flags", 32'(out_flags), 32'(vecs[i].flags));
      check("vec_count", 32'(out_count), 32'(i + 1));
      idle(1'b1);
      check("vec_empty_valid", 32'(out_valid), 32'h0);
      check("vec_empty_F", out_F, 32'h0);
      check("vec_empty_flags", 32'(out_flags), 32'h0);
    end

    // Backpressure: third push must be refused while FULL.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    push_simple(32'h1, 1'b0);
    check("bp_ready_after1", 32'(in_ready), 32'h1);
    push_simple(32'h2, 1'b0);
    check("bp_ready_after2", 32'(in_ready), 32'h0);
    push_simple(32'h3, 1'b0);
    check("bp_head_held", out_F, 32'h1);
    check("bp_count", 32'(out_count), 32'h2);
    idle(1'b1);
    check("bp_second_F", out_F, 32'h2);
    check("bp_ready_reopen", 32'(in_ready), 32'h1);
    idle(1'b1);
    check("bp_drained", 32'(out_valid), 32'h0);
    check("bp_count_final", 32'(out_count), 32'h2);

    // Simultaneous push and pop in ONE keeps occupancy at one.
    push_simple(32'hA, 1'b0);
    push_simple(32'hB, 1'b1);
    check("pp_valid", 32'(out_valid), 32'h1);
    check("pp_ready", 32'(in_ready), 32'h1);
    check("pp_F", out_F, 32'hB);
    idle(1'b1);
    check("pp_empty", 32'(out_valid), 32'h0);

    // Reset from FULL with push and pop requested at the same edge.
    push_simple(32'h11, 1'b0);
    push_simple(32'h22, 1'b0);
    check("full_ready", 32'(in_ready), 32'h0);
    cyc(1'b1, 1'b1, 32'h33, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);
    check("frst_valid", 32'(out_valid), 32'h0);
    check("frst_ready", 32'(in_ready), 32'h1);
    check("frst_count", 32'(out_count), 32'h0);
    check("frst_F", out_F, 32'h0);

    // Random traffic; long enough to wrap the narrow counter.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] f;
      logic        co;
      logic [3:0]  s;
      logic        a;
      logic        b;
      f  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      co = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(0, 15));
      a  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      cyc(1'b0, 1'($urandom_range(0, 1)), f, co, s, a, b, flags_model(f, co, s, a, b),
          $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
    check("drain_empty", 32'(q.size()), 32'h0);
    check("rand_count", 32'(out_count), 32'(TB_CNT_W'(n_push)));
    idle(1'b1);
    check("rand_final_valid", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter CNT_W, default 16: width of the accepted-result counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  ALU result on F/Cout/sel/A_msb/B_msb is valid this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 F  input  32  ALU result word.
REQ-007 Cout  input  1  ALU carry-out.
REQ-008 sel  input  4  ALU operation select that produced F.
REQ-009 A_msb  input  1  bit 31 of ALU operand A.
REQ-010 B_msb  input  1  bit 31 of ALU operand B.
REQ-011 out_valid  output  1  out_F/out_flags hold a valid buffered result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 out_F  output  32  buffered result word.
REQ-014 out_flags  output  4  {V,C,N,Z} for out_F.
REQ-015 out_count  output  CNT_W  number of results accepted since reset.

Function
REQ-016 Block SHALL be a 2-entry FIFO with states EMPTY, ONE, FULL (occupancy 0/1/2).
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it SHALL be a registered function of state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY; latency from push to out_valid SHALL be exactly 1 cycle.
REQ-020 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop; all other cases SHALL hold the current state.
REQ-021 Output order SHALL be FIFO order; out_F/out_flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Z SHALL be 1 if F==32'h00000000; N SHALL equal F[31].
REQ-023 C SHALL equal Cout when sel[3:2]==2'b00 and SHALL be 0 otherwise, because Cout is not defined for logic and shift operations.
REQ-024 Flags SHALL be computed from the inputs at push time and stored with the entry.
REQ-025 out_count SHALL increment by 1 on each push and wrap from all-ones to 0.
REQ-026 When out_valid=0, out_F and out_flags SHALL be 0.

Reset
REQ-027 On rst=1 at a clock edge, the state SHALL become EMPTY and out_count, out_F, and out_flags SHALL become 0; in_ready SHALL be 1 and out_valid SHALL be 0 in the cycle after reset.
REQ-028 rst SHALL take priority over a simultaneous push or pop; buffered entries SHALL be discarded on reset mid-operation.

Configuration
REQ-029 With ALU_RES_OVF_EN defined, V SHALL be computed as follows:
- sel==4'h1: (A_msb==B_msb) && (F[31]!=A_msb).
- sel==4'h2: (A_msb!=B_msb) && (F[31]!=A_msb).
- Otherwise: 0.
REQ-030 With ALU_RES_OVF_EN undefined, V SHALL be tied to 0, with no overflow logic present.

Verification
REQ-031 Reset, then a single push of F=32'h00000000, Cout=0, sel=4'h0 -> out_valid=1 the next cycle, out_flags=4'b0001, out_count=1.
REQ-032 Push F=32'h7FFFFFFF, Cout=0, sel=4'h1, A_msb=1, B_msb=0 -> out_flags=4'b0000.
REQ-032 (cont.) Then push F=32'h00000000, Cout=1, sel=4'h1, A_msb=1, B_msb=1 -> out_flags=4'b1101 with the macro defined, or 4'b0101 without it.
REQ-033 Hold out_ready=0 and push three results 32'h1, 32'h2, 32'h3:
- in_ready SHALL drop after the second push.
- The third result SHALL not be accepted.
- After out_ready=1, the outputs SHALL be 32'h1 then 32'h2.
- out_count SHALL be 2.
REQ-034 In state ONE, assert push and pop in the same cycle with 32'hA then 32'hB -> the state SHALL remain ONE and the next out_F SHALL be 32'hB.
REQ-035 Push F=32'h2468ACF0, Cout=1, sel=4'h8 -> C=0, N=0, Z=0.
REQ-036 Assert rst while in FULL -> the next cycle SHALL show out_valid=0, in_ready=1, out_count=0.
